// File: rtl/config_tile_multi.sv
// Daisy-chained multi-segment config tile: shadow shift chain with atomic commit,
// bit counting, short-commit error and hard/soft path select. Optional: CONFIG_READBACK_EN.
module config_tile_multi #(
    parameter int NUM_SEG = 4,
    parameter int SEG_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_soft,
    input  logic                     set_hard,
    input  logic                     shift_in_soft,
    input  logic                     shift_in_hard,
    input  logic                     commit_soft,
    input  logic                     commit_hard,
`ifdef CONFIG_READBACK_EN
    input  logic                     readback_soft,
    input  logic                     readback_hard,
`endif
    output logic                     shift_out,
    output logic [NUM_SEG*SEG_W-1:0] cfg_out,
    output logic                     hard_mode,
    output logic                     cfg_valid,
    output logic [NUM_SEG-1:0]       seg_update,
    output logic                     cfg_err
);

    localparam int CFG_W = NUM_SEG * SEG_W;
    localparam int L     = CFG_W + 1;
    localparam int CNT_W = $clog2(L + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(L);

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_e;

    state_e             state_q, state_d;
    logic [L-1:0]       shadow_q, shadow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CFG_W-1:0]   cfg_q, cfg_d;
    logic               hard_mode_q, hard_mode_d;
    logic               cfg_valid_q, cfg_valid_d;
    logic [NUM_SEG-1:0] seg_update_q, seg_update_d;
    logic               cfg_err_q, cfg_err_d;

    logic shift_en, din, commit, readback;

    // The committed mode bit picks the live path; the other path's strobes are ignored.
    always_comb begin
        shift_en = hard_mode_q ? set_hard      : set_soft;
        din      = hard_mode_q ? shift_in_hard : shift_in_soft;
        commit   = hard_mode_q ? commit_hard   : commit_soft;
`ifdef CONFIG_READBACK_EN
        readback = hard_mode_q ? readback_hard : readback_soft;
`else
        readback = 1'b0;
`endif
    end

    always_comb begin
        shadow_d     = shadow_q;
        cnt_d        = cnt_q;
        cfg_d        = cfg_q;
        hard_mode_d  = hard_mode_q;
        cfg_valid_d  = cfg_valid_q;
        seg_update_d = '0;
        cfg_err_d    = cfg_err_q;

        if (commit) begin
            // A shift in the commit cycle still lands and becomes bit 1 of the next frame.
            if (shift_en) begin
                shadow_d = {shadow_q[L-2:0], din};
                cnt_d    = CNT_W'(1);
            end else begin
                cnt_d    = '0;
            end
            if (state_q == FULL) begin
                cfg_d       = shadow_q[CFG_W-1:0];
                hard_mode_d = shadow_q[L-1];
                cfg_valid_d = 1'b1;
                cfg_err_d   = 1'b0;
                for (int k = 0; k < NUM_SEG; k++) begin
                    seg_update_d[k] = (shadow_q[k*SEG_W +: SEG_W] != cfg_q[k*SEG_W +: SEG_W]);
                end
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (readback) begin
            shadow_d = {hard_mode_q, cfg_q};
            cnt_d    = CNT_FULL;
        end else if (shift_en) begin
            shadow_d = {shadow_q[L-2:0], din};
            cnt_d    = (cnt_q == CNT_FULL) ? CNT_FULL : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = PARTIAL;
        if (cnt_d == '0) begin
            state_d = EMPTY;
        end else if (cnt_d == CNT_FULL) begin
            state_d = FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= EMPTY;
            shadow_q     <= '0;
            cnt_q        <= '0;
            cfg_q        <= '0;
            hard_mode_q  <= 1'b0;
            cfg_valid_q  <= 1'b0;
            seg_update_q <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            cnt_q        <= cnt_d;
            cfg_q        <= cfg_d;
            hard_mode_q  <= hard_mode_d;
            cfg_valid_q  <= cfg_valid_d;
            seg_update_q <= seg_update_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign shift_out  = shadow_q[L-1];
    assign cfg_out    = cfg_q;
    assign hard_mode  = hard_mode_q;
    assign cfg_valid  = cfg_valid_q;
    assign seg_update = seg_update_q;
    assign cfg_err    = cfg_err_q;

endmodule
